pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits.
REQ-002 Parameter STEP, default 4: sequential increment in bytes; SHALL be a power of two, 1 <= STEP < 2^WIDTH.
REQ-003 Parameter RESET_ADDR, default 0: PC value loaded on reset; SHALL be a multiple of STEP.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 halt  input  1  level request to enter HALTED.
REQ-007 resume  input  1  one-cycle request to leave HALTED.
REQ-008 redir_valid  input  1  redirect request this cycle.
REQ-009 redir_rel  input  1  1 = target is PC-relative signed offset; 0 = absolute address.
REQ-010 redir_addr  input  WIDTH  absolute target or two's-complement offset.
REQ-011 pc_ready  input  1  fetch stage accepts pc_out this cycle.
REQ-012 pc_out  output  WIDTH  current PC, registered.
REQ-013 pc_valid  output  1  pc_out is offered to fetch.
REQ-014 pc_plus  output  WIDTH  combinational pc_out + STEP, modulo 2^WIDTH.
REQ-015 redir_err  output  1  one-cycle pulse: redirect rejected as misaligned.
REQ-016 wrap  output  1  one-cycle pulse: sequential advance wrapped past 2^WIDTH-1.
REQ-017 state  output  2  current state: 0 IDLE, 1 RUN, 2 HALTED.

Function
REQ-018 States: IDLE, RUN, HALTED; IDLE entered only by reset.
REQ-019 IDLE -> RUN unconditionally on the first clock edge after reset deasserts; pc_valid = 0 in IDLE.
REQ-020 RUN: pc_valid = 1; HALTED: pc_valid = 0.
REQ-021 RUN -> HALTED when halt = 1 at the edge; HALTED -> RUN when resume = 1 and halt = 0; halt and resume both 1 keeps/enters HALTED.
REQ-022 Accept = pc_valid & pc_ready; on accept without redirect, pc_out <= pc_out + STEP modulo 2^WIDTH.
REQ-023 wrap SHALL pulse in the cycle after an accept-driven advance whose sum carried out of WIDTH bits; redirect-driven loads never set wrap.
REQ-024 Redirect target T = redir_addr if redir_rel = 0, else pc_out + redir_addr modulo 2^WIDTH (current pc_out, not pc_plus).
REQ-025 Redirect accepted when redir_valid = 1 and T mod STEP = 0: pc_out <= T at the edge, in any state except IDLE.
REQ-026 Redirect has priority over advance; redirect coincident with accept: the offered PC counts as consumed, next pc_out = T.
REQ-027 Misaligned T: pc_out holds or advances as if redir_valid = 0; redir_err pulses 1 in the following cycle.
REQ-028 Redirect in HALTED loads pc_out and remains HALTED; redirect coincident with halt is applied and HALTED is entered.
REQ-029 redir_valid in IDLE SHALL be ignored with no redir_err pulse.
REQ-030 pc_valid with pc_ready = 0: pc_out SHALL stay stable until accept, redirect or halt.
REQ-031 pc_plus SHALL track pc_out with zero latency in all states.

Reset
REQ-032 reset = 1 SHALL immediately and asynchronously force pc_out = RESET_ADDR, state = IDLE, pc_valid = 0, redir_err = 0, wrap = 0.
REQ-033 Reset mid-operation (any state, pending redirect or halt) SHALL discard all in-flight requests; no output pulse follows reset deassertion.
REQ-034 Reset deassertion is synchronous to clk at the integration level; the block adds no synchronizer.

Verification
REQ-035 Defaults; reset, release, pc_ready = 1 for 4 cycles -> IDLE one cycle, then pc_out 0, 4, 8, 12; pc_plus always pc_out + 4.
REQ-036 pc_out = 0x10, pc_ready = 0 for 3 cycles, then 1 -> pc_out holds 0x10 three cycles, then 0x14.
REQ-037 pc_out = 0x20, accept plus redir_valid, redir_rel = 1, redir_addr = 0xFFFFFFF8 -> pc_out = 0x18; absolute 0x102 -> no load, pc_out advances to 0x24, redir_err pulses once.
REQ-038 halt at pc_out = 0x40, redirect absolute 0x80 while HALTED, then resume -> pc_valid 0 while halted, pc_out = 0x80, RUN resumes at 0x80.
REQ-039 WIDTH = 8, STEP = 4, pc_out = 0xFC, accept -> pc_out = 0x00, wrap pulses one cycle.
REQ-040 Assert reset asynchronously mid-cycle during RUN with redirect pending -> pc_out = RESET_ADDR and pc_valid = 0 before the next edge; redirect never applied.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer. Offers a registered PC to the fetch
// stage, advances by STEP on each accepted PC, and takes absolute or
// PC-relative redirects. A three-state FSM (IDLE/RUN/HALTED) controls
// when the PC is offered.
//
// Handshake: pc_valid/pc_ready follow strict valid/ready rules. A PC is
// consumed on a rising edge where pc_valid and pc_ready are both 1. While
// pc_valid is 1 and pc_ready is 0, pc_out holds until a redirect or a halt
// changes it. pc_valid never depends on pc_ready.
module pc_seq #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic             resume,
    input  logic             redir_valid,
    input  logic             redir_rel,
    input  logic [WIDTH-1:0] redir_addr,
    input  logic             pc_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc_plus,
    output logic             redir_err,
    output logic             wrap,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // STEP is a power of two, so alignment is a mask test on the low bits.
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] pc_q;
    logic             redir_err_q;
    logic             wrap_q;

    logic [WIDTH:0]   seq_sum;
    logic [WIDTH-1:0] redir_target;
    logic             target_aligned;
    logic             redir_active;
    logic             redir_take;
    logic             redir_bad;
    logic             accept;

    // Sequential sum keeps the carry bit so a wrap past 2^WIDTH-1 is visible.
    assign seq_sum        = {1'b0, pc_q} + {1'b0, STEP_W};
    // Relative redirects use the current PC, not the incremented one.
    assign redir_target   = redir_rel ? (pc_q + redir_addr) : redir_addr;
    assign target_aligned = (redir_target & ALIGN_MASK) == '0;
    // Redirects are ignored entirely while in IDLE.
    assign redir_active   = redir_valid && (state_q != S_IDLE);
    assign redir_take     = redir_active && target_aligned;
    assign redir_bad      = redir_active && !target_aligned;
    assign accept         = pc_valid && pc_ready;

    // State register; reset returns the sequencer to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt dominates resume; IDLE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_RUN;
            S_RUN:    if (halt) state_d = S_HALTED;
            S_HALTED: if (resume && !halt) state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: the PC is offered only while running.
    always_comb begin
        pc_valid = 1'b0;
        if (state_q == S_RUN) pc_valid = 1'b1;
    end

    // PC datapath and one-cycle status pulses; redirect beats sequential advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_ADDR;
            redir_err_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            redir_err_q <= redir_bad;
            wrap_q      <= 1'b0;
            if (redir_take) begin
                pc_q <= redir_target;
            end else if (accept) begin
                pc_q   <= seq_sum[WIDTH-1:0];
                wrap_q <= seq_sum[WIDTH];
            end
        end
    end

    assign pc_out    = pc_q;
    assign pc_plus   = seq_sum[WIDTH-1:0];
    assign redir_err = redir_err_q;
    assign wrap      = wrap_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed bench for pc_seq. A default 32-bit instance covers
// run, stall, redirect, halt and asynchronous reset; an 8-bit instance
// covers the wrap pulse.
module tb_pc_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // default instance signals
    logic        reset, halt, resume, redir_valid, redir_rel, pc_ready;
    logic [31:0] redir_addr;
    logic [31:0] pc_out, pc_plus;
    logic        pc_valid, redir_err, wrap;
    logic [1:0]  state;

    // 8-bit instance signals
    logic       w8_reset, w8_halt, w8_resume, w8_redir_valid, w8_redir_rel, w8_pc_ready;
    logic [7:0] w8_redir_addr;
    logic [7:0] w8_pc_out, w8_pc_plus;
    logic       w8_pc_valid, w8_redir_err, w8_wrap;
    logic [1:0] w8_state;

    pc_seq dut (
        .clk(clk), .reset(reset), .halt(halt), .resume(resume),
        .redir_valid(redir_valid), .redir_rel(redir_rel), .redir_addr(redir_addr),
        .pc_ready(pc_ready), .pc_out(pc_out), .pc_valid(pc_valid),
        .pc_plus(pc_plus), .redir_err(redir_err), .wrap(wrap), .state(state)
    );

    pc_seq #(.WIDTH(8), .STEP(4), .RESET_ADDR(8'h00)) dut8 (
        .clk(clk), .reset(w8_reset), .halt(w8_halt), .resume(w8_resume),
        .redir_valid(w8_redir_valid), .redir_rel(w8_redir_rel), .redir_addr(w8_redir_addr),
        .pc_ready(w8_pc_ready), .pc_out(w8_pc_out), .pc_valid(w8_pc_valid),
        .pc_plus(w8_pc_plus), .redir_err(w8_redir_err), .wrap(w8_wrap), .state(w8_state)
    );

    // ---------------- driver tasks ----------------
    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_redir(input logic v, input logic rel, input logic [31:0] addr);
        redir_valid = v;
        redir_rel   = rel;
        redir_addr  = addr;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        tick();
        tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc act=%h exp=%h", pc_out, 32'h0); end
        tests_run++; if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state act=%0d exp=0", state); end
        tests_run++; if (pc_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid act=%b exp=0", pc_valid); end
        tests_run++; if (redir_err !== 1'b0 || wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses err=%b wrap=%b exp=0/0", redir_err, wrap); end
        reset    = 1'b0;
        w8_reset = 1'b0;
    endtask

    task automatic test_basic_run();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        tests_run++; if (state !== 2'd0 || pc_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_cycle state=%0d valid=%b exp=0/0", state, pc_valid); end
        pc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (pc_out !== exp_pc[i]) begin tests_failed++; $display("FAIL run_pc[%0d] act=%h exp=%h", i, pc_out, exp_pc[i]); end
            tests_run++; if (pc_plus !== exp_pc[i] + 32'h4) begin tests_failed++; $display("FAIL run_plus[%0d] act=%h exp=%h", i, pc_plus, exp_pc[i] + 32'h4); end
            tests_run++; if (state !== 2'd1 || pc_valid !== 1'b1) begin tests_failed++; $display("FAIL run_state[%0d] state=%0d valid=%b exp=1/1", i, state, pc_valid); end
        end
    endtask

    task automatic test_stall();
        tick();
        tests_run++; if (pc_out !== 32'h10) begin tests_failed++; $display("FAIL stall_start act=%h exp=%h", pc_out, 32'h10); end
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (pc_out !== 32'h10 || pc_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold[%0d] pc=%h valid=%b exp=%h/1", i, pc_out, pc_valid, 32'h10); end
        end
        pc_ready = 1'b1;
        tick();
        tests_run++; if (pc_out !== 32'h14) begin tests_failed++; $display("FAIL stall_release act=%h exp=%h", pc_out, 32'h14); end
    endtask

    task automatic test_redirect();
        // absolute redirect coincident with accept: redirect wins
        set_redir(1'b1, 1'b0, 32'h20);
        tick();
        tests_run++; if (pc_out !== 32'h20 || redir_err !== 1'b0) begin tests_failed++; $display("FAIL redir_abs pc=%h err=%b exp=%h/0", pc_out, redir_err, 32'h20); end
        // relative -8 from 0x20
        set_redir(1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        tests_run++; if (pc_out !== 32'h18 || redir_err !== 1'b0) begin tests_failed++; $display("FAIL redir_rel pc=%h err=%b exp=%h/0", pc_out, redir_err, 32'h18); end
        set_redir(1'b1, 1'b0, 32'h20);
        tick();
        // misaligned absolute with accept: advance instead, error pulse
        set_redir(1'b1, 1'b0, 32'h102);
        tick();
        tests_run++; if (pc_out !== 32'h24 || redir_err !== 1'b1) begin tests_failed++; $display("FAIL redir_misalign pc=%h err=%b exp=%h/1", pc_out, redir_err, 32'h24); end
        set_redir(1'b0, 1'b0, 32'h0);
        tick();
        tests_run++; if (pc_out !== 32'h28 || redir_err !== 1'b0) begin tests_failed++; $display("FAIL redir_err_once pc=%h err=%b exp=%h/0", pc_out, redir_err, 32'h28); end
        // misaligned relative while stalled: hold, error pulse
        pc_ready = 1'b0;
        set_redir(1'b1, 1'b1, 32'h1);
        tick();
        tests_run++; if (pc_out !== 32'h28 || redir_err !== 1'b1) begin tests_failed++; $display("FAIL redir_rel_misalign pc=%h err=%b exp=%h/1", pc_out, redir_err, 32'h28); end
        set_redir(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_halt();
        set_redir(1'b1, 1'b0, 32'h40);
        tick();
        set_redir(1'b0, 1'b0, 32'h0);
        tests_run++; if (pc_out !== 32'h40) begin tests_failed++; $display("FAIL halt_setup act=%h exp=%h", pc_out, 32'h40); end
        halt = 1'b1;
        tick();
        tests_run++; if (state !== 2'd2 || pc_valid !== 1'b0 || pc_out !== 32'h40) begin tests_failed++; $display("FAIL halt_enter state=%0d valid=%b pc=%h exp=2/0/%h", state, pc_valid, pc_out, 32'h40); end
        halt     = 1'b0;
        pc_ready = 1'b1;
        set_redir(1'b1, 1'b0, 32'h80);
        tick();
        set_redir(1'b0, 1'b0, 32'h0);
        tests_run++; if (state !== 2'd2 || pc_valid !== 1'b0 || pc_out !== 32'h80) begin tests_failed++; $display("FAIL halt_redir state=%0d valid=%b pc=%h exp=2/0/%h", state, pc_valid, pc_out, 32'h80); end
        halt   = 1'b1;
        resume = 1'b1;
        tick();
        tests_run++; if (state !== 2'd2 || pc_out !== 32'h80) begin tests_failed++; $display("FAIL halt_resume_both state=%0d pc=%h exp=2/%h", state, pc_out, 32'h80); end
        halt = 1'b0;
        tick();
        resume = 1'b0;
        tests_run++; if (state !== 2'd1 || pc_valid !== 1'b1 || pc_out !== 32'h80) begin tests_failed++; $display("FAIL resume state=%0d valid=%b pc=%h exp=1/1/%h", state, pc_valid, pc_out, 32'h80); end
        tick();
        tests_run++; if (pc_out !== 32'h84) begin tests_failed++; $display("FAIL resume_advance act=%h exp=%h", pc_out, 32'h84); end
        pc_ready = 1'b0;
    endtask

    task automatic test_wrap();
        w8_redir_valid = 1'b1;
        w8_redir_rel   = 1'b0;
        w8_redir_addr  = 8'hFC;
        w8_pc_ready    = 1'b1;
        tick();
        w8_redir_valid = 1'b0;
        tests_run++; if (w8_pc_out !== 8'hFC || w8_wrap !== 1'b0) begin tests_failed++; $display("FAIL wrap_setup pc=%h wrap=%b exp=fc/0", w8_pc_out, w8_wrap); end
        tests_run++; if (w8_pc_plus !== 8'h00) begin tests_failed++; $display("FAIL wrap_plus act=%h exp=00", w8_pc_plus); end
        tick();
        tests_run++; if (w8_pc_out !== 8'h00 || w8_wrap !== 1'b1) begin tests_failed++; $display("FAIL wrap_pulse pc=%h wrap=%b exp=00/1", w8_pc_out, w8_wrap); end
        tick();
        w8_pc_ready = 1'b0;
        tests_run++; if (w8_pc_out !== 8'h04 || w8_wrap !== 1'b0) begin tests_failed++; $display("FAIL wrap_once pc=%h wrap=%b exp=04/0", w8_pc_out, w8_wrap); end
        // relative -4 from 0x04 carries in the adder but must not set wrap
        w8_redir_valid = 1'b1;
        w8_redir_rel   = 1'b1;
        w8_redir_addr  = 8'hFC;
        tick();
        w8_redir_valid = 1'b0;
        tests_run++; if (w8_pc_out !== 8'h00 || w8_wrap !== 1'b0) begin tests_failed++; $display("FAIL wrap_redir pc=%h wrap=%b exp=00/0", w8_pc_out, w8_wrap); end
    endtask

    task automatic test_async_reset();
        pc_ready = 1'b1;
        set_redir(1'b1, 1'b0, 32'h100);
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (pc_out !== 32'h0 || pc_valid !== 1'b0 || state !== 2'd0) begin tests_failed++; $display("FAIL async_reset pc=%h valid=%b state=%0d exp=0/0/0", pc_out, pc_valid, state); end
        tick();
        reset = 1'b0;
        tests_run++; if (pc_out !== 32'h0 || redir_err !== 1'b0 || wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_hold pc=%h err=%b wrap=%b exp=0/0/0", pc_out, redir_err, wrap); end
        // redirect still asserted through the IDLE cycle must be ignored
        tick();
        set_redir(1'b0, 1'b0, 32'h0);
        pc_ready = 1'b0;
        tests_run++; if (state !== 2'd1 || pc_out !== 32'h0 || redir_err !== 1'b0) begin tests_failed++; $display("FAIL idle_redir state=%0d pc=%h err=%b exp=1/0/0", state, pc_out, redir_err); end
        tick();
        tests_run++; if (pc_out !== 32'h0 || redir_err !== 1'b0 || wrap !== 1'b0) begin tests_failed++; $display("FAIL post_reset pc=%h err=%b wrap=%b exp=0/0/0", pc_out, redir_err, wrap); end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset = 1'b1; halt = 1'b0; resume = 1'b0; pc_ready = 1'b0;
        set_redir(1'b0, 1'b0, 32'h0);
        w8_reset = 1'b1; w8_halt = 1'b0; w8_resume = 1'b0; w8_pc_ready = 1'b0;
        w8_redir_valid = 1'b0; w8_redir_rel = 1'b0; w8_redir_addr = 8'h0;

        test_reset();
        test_basic_run();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
